// File: rtl/updn_cntr_n_if.sv
// Signal bundle for the updn_cntr_n counter: control/load inputs and counter status outputs.
// The master drives commands; the slave (the counter) returns value, state and flags.
interface updn_cntr_n_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             inc;
  logic             en;
  logic             sat;
  logic             clr_ovf;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] q;
  logic [2:0]       state;
  logic             carry;
  logic             borrow;
  logic             ovf;
  logic             is_max;
  logic             is_zero;

  modport master (
    output load, inc, en, sat, clr_ovf, d_in,
    input  q, state, carry, borrow, ovf, is_max, is_zero
  );

  modport slave (
    input  load, inc, en, sat, clr_ovf, d_in,
    output q, state, carry, borrow, ovf, is_max, is_zero
  );
endinterface

// File: rtl/updn_cntr_n.sv
// Parametrised up/down counter with load, hold, wrap/saturate mode, carry/borrow pulses
// and a sticky overflow flag; the operation is selected by a registered control FSM.
module updn_cntr_n #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  updn_cntr_n_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_INC  = 3'b010,
    ST_DEC  = 3'b100,
    ST_HOLD = 3'b110
  } state_e;

  localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q,   ovf_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic             inc_ovf;
  logic             dec_unf;

  // The extra MSB of each WIDTH+1 result is the overflow / underflow indication.
  assign sum_w   = {1'b0, cnt_q} + STEP_W;
  assign dif_w   = {1'b0, cnt_q} - STEP_W;
  assign inc_ovf = sum_w[WIDTH];
  assign dec_unf = dif_w[WIDTH];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = ST_IDLE;
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOAD, ST_INC, ST_DEC, ST_HOLD: begin
        if (bus.load)     state_d = ST_LOAD;
        else if (!bus.en) state_d = ST_HOLD;
        else if (bus.inc) state_d = ST_INC;
        else              state_d = ST_DEC;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_LOAD: cnt_d = bus.d_in;
      ST_INC: begin
        carry_d = inc_ovf;
        if (inc_ovf && bus.sat) cnt_d = MAX_VAL;
        else                    cnt_d = sum_w[WIDTH-1:0];
      end
      ST_DEC: begin
        borrow_d = dec_unf;
        if (dec_unf && bus.sat) cnt_d = '0;
        else                    cnt_d = dif_w[WIDTH-1:0];
      end
      default: cnt_d = cnt_q;
    endcase

    // A new carry/borrow outranks a clear arriving on the same edge.
    ovf_d = carry_d | borrow_d |
            (ovf_q & ~bus.clr_ovf & (state_d != ST_LOAD));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.q       = cnt_q;
  assign bus.state   = state_q;
  assign bus.carry   = carry_q;
  assign bus.borrow  = borrow_q;
  assign bus.ovf     = ovf_q;
  assign bus.is_max  = (cnt_q == MAX_VAL);
  assign bus.is_zero = (cnt_q == '0);

endmodule

// File: tb/tb_updn_cntr_n.sv
// Self-checking bench: three counter configurations share one command stream and are
// compared every cycle against an arithmetic reference model; directed cases come first.
module tb_updn_cntr_n;

  logic        clk;
  logic        reset_n;
  logic        load, inc, en, sat, clr_ovf;
  logic [15:0] d_in;

  int n_tests = 0;
  int n_fail  = 0;

  updn_cntr_n_if #(.WIDTH(8))  if0 ();
  updn_cntr_n_if #(.WIDTH(8))  if1 ();
  updn_cntr_n_if #(.WIDTH(16)) if2 ();

  updn_cntr_n #(.WIDTH(8),  .STEP(1))   u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  updn_cntr_n #(.WIDTH(8),  .STEP(3))   u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  updn_cntr_n #(.WIDTH(16), .STEP(256)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

  assign {if0.load, if0.inc, if0.en, if0.sat, if0.clr_ovf} = {load, inc, en, sat, clr_ovf};
  assign {if1.load, if1.inc, if1.en, if1.sat, if1.clr_ovf} = {load, inc, en, sat, clr_ovf};
  assign {if2.load, if2.inc, if2.en, if2.sat, if2.clr_ovf} = {load, inc, en, sat, clr_ovf};
  assign if0.d_in = d_in[7:0];
  assign if1.d_in = d_in[7:0];
  assign if2.d_in = d_in;

  logic [15:0] obs_q  [3];
  logic [2:0]  obs_st [3];
  logic        obs_c  [3];
  logic        obs_b  [3];
  logic        obs_o  [3];
  logic        obs_mx [3];
  logic        obs_z  [3];

  assign obs_q[0] = {8'h00, if0.q};
  assign obs_q[1] = {8'h00, if1.q};
  assign obs_q[2] = if2.q;
  assign obs_st   = '{if0.state,   if1.state,   if2.state};
  assign obs_c    = '{if0.carry,   if1.carry,   if2.carry};
  assign obs_b    = '{if0.borrow,  if1.borrow,  if2.borrow};
  assign obs_o    = '{if0.ovf,     if1.ovf,     if2.ovf};
  assign obs_mx   = '{if0.is_max,  if1.is_max,  if2.is_max};
  assign obs_z    = '{if0.is_zero, if1.is_zero, if2.is_zero};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: value, pulses, sticky flag and expected state code per instance.
  typedef struct {
    int       q;
    bit       c;
    bit       b;
    bit       o;
    bit [2:0] st;
  } mdl_t;

  mdl_t m [3];
  int   widths [3] = '{8, 8, 16};
  int   steps  [3] = '{1, 3, 256};

  function automatic mdl_t mdl_next(mdl_t cur, int w, int s, bit ld, bit up, bit e,
                                    bit st, bit clr, int d);
    mdl_t r;
    int   mx;
    int   t;
    mx  = (1 << w) - 1;
    r   = cur;
    r.c = 1'b0;
    r.b = 1'b0;
    if (ld) begin
      r.st = 3'b001;
      r.q  = d & mx;
    end else if (!e) begin
      r.st = 3'b110;
    end else if (up) begin
      r.st = 3'b010;
      t    = cur.q + s;
      if (t > mx) begin
        r.c = 1'b1;
        r.q = st ? mx : t - (mx + 1);
      end else begin
        r.q = t;
      end
    end else begin
      r.st = 3'b100;
      if (cur.q < s) begin
        r.b = 1'b1;
        r.q = st ? 0 : cur.q - s + mx + 1;
      end else begin
        r.q = cur.q - s;
      end
    end
    if (ld || clr) r.o = 1'b0;
    if (r.c || r.b) r.o = 1'b1;
    return r;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 3; k++) m[k] = '{q: 0, c: 1'b0, b: 1'b0, o: 1'b0, st: 3'b000};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int mx;
    for (int k = 0; k < 3; k++) begin
      mx = (1 << widths[k]) - 1;
      check($sformatf("i%0d_q", k),       32'(obs_q[k]),  32'(m[k].q));
      check($sformatf("i%0d_state", k),   32'(obs_st[k]), 32'(m[k].st));
      check($sformatf("i%0d_carry", k),   32'(obs_c[k]),  32'(m[k].c));
      check($sformatf("i%0d_borrow", k),  32'(obs_b[k]),  32'(m[k].b));
      check($sformatf("i%0d_ovf", k),     32'(obs_o[k]),  32'(m[k].o));
      check($sformatf("i%0d_is_max", k),  32'(obs_mx[k]), 32'(m[k].q == mx));
      check($sformatf("i%0d_is_zero", k), 32'(obs_z[k]),  32'(m[k].q == 0));
    end
  endtask

  task automatic drive(input bit ld, input bit up, input bit e, input bit st, input bit clr,
                       input logic [15:0] d);
    load    = ld;
    inc     = up;
    en      = e;
    sat     = st;
    clr_ovf = clr;
    d_in    = d;
  endtask

  // One clock: advance the model with the inputs sampled at the edge, then compare.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++)
      m[k] = mdl_next(m[k], widths[k], steps[k], load, inc, en, sat, clr_ovf, int'(d_in));
    #1;
    check_all();
  endtask

  // Pulse reset between edges; outputs must clear without any clock edge.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    mdl_reset();
    check_all();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] d_pick;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0000);
    mdl_reset();
    #2;
    check_all();
    check("rst_state", 32'(obs_st[0]), 32'h0);
    check("rst_is_zero", 32'(obs_z[0]), 32'h1);
    #1 reset_n = 1'b1;

    // Reset mid-count, then release into hold.
    drive(1, 0, 0, 0, 0, 16'h005A); step();
    check("mid_q_5a", 32'(obs_q[0]), 32'h5A);
    drive(0, 0, 0, 0, 0, 16'h0000);
    async_reset();
    check("rst_mid_q", 32'(obs_q[0]), 32'h0);
    step();
    check("rel_hold_state", 32'(obs_st[0]), 32'h6);
    check("rel_hold_q", 32'(obs_q[0]), 32'h0);

    // Increment across wrap (STEP=1, sat=0).
    drive(1, 0, 1, 0, 0, 16'h00FE); step();
    check("wrap_q0", 32'(obs_q[0]), 32'hFE);
    drive(0, 1, 1, 0, 0, 16'h0000);
    step(); check("wrap_q1", 32'(obs_q[0]), 32'hFF); check("wrap_c1", 32'(obs_c[0]), 32'h0);
    step(); check("wrap_q2", 32'(obs_q[0]), 32'h00); check("wrap_c2", 32'(obs_c[0]), 32'h1);
    step(); check("wrap_q3", 32'(obs_q[0]), 32'h01); check("wrap_c3", 32'(obs_c[0]), 32'h0);
    check("wrap_ovf", 32'(obs_o[0]), 32'h1);

    // Saturation with STEP=3.
    drive(1, 0, 0, 1, 0, 16'h00FD); step();
    drive(0, 1, 1, 1, 0, 16'h0000);
    step(); check("sat_up_q1", 32'(obs_q[1]), 32'hFF); check("sat_up_c1", 32'(obs_c[1]), 32'h1);
    step(); check("sat_up_q2", 32'(obs_q[1]), 32'hFF); check("sat_up_c2", 32'(obs_c[1]), 32'h1);
    drive(1, 0, 0, 1, 0, 16'h0002); step();
    drive(0, 0, 1, 1, 0, 16'h0000); step();
    check("sat_dn_q", 32'(obs_q[1]), 32'h00);
    check("sat_dn_b", 32'(obs_b[1]), 32'h1);
    check("sat_dn_ovf", 32'(obs_o[1]), 32'h1);

    // Load priority over enable/direction, and load clears ovf.
    drive(1, 1, 0, 0, 0, 16'h0033); step();
    check("prio_state", 32'(obs_st[0]), 32'h1);
    check("prio_q", 32'(obs_q[0]), 32'h33);
    check("prio_ovf", 32'(obs_o[0]), 32'h0);
    drive(0, 0, 0, 0, 0, 16'h0000); step();
    check("prio_hold_state", 32'(obs_st[0]), 32'h6);
    check("prio_hold_q", 32'(obs_q[0]), 32'h33);

    // Set beats clear on the same edge.
    drive(1, 0, 1, 0, 0, 16'h0000); step();
    drive(0, 0, 1, 0, 1, 16'h0000); step();
    check("race_q", 32'(obs_q[0]), 32'hFF);
    check("race_b", 32'(obs_b[0]), 32'h1);
    check("race_ovf_set", 32'(obs_o[0]), 32'h1);
    drive(0, 0, 0, 0, 1, 16'h0000); step();
    check("race_ovf_clr", 32'(obs_o[0]), 32'h0);

    // Wide configuration, STEP=0x100.
    drive(1, 0, 1, 0, 0, 16'hFF80); step();
    drive(0, 1, 1, 0, 0, 16'h0000); step();
    check("wide_inc_q", 32'(obs_q[2]), 32'h0080);
    check("wide_inc_c", 32'(obs_c[2]), 32'h1);
    drive(0, 0, 1, 0, 0, 16'h0000); step();
    check("wide_dec_q", 32'(obs_q[2]), 32'hFF80);
    check("wide_dec_b", 32'(obs_b[2]), 32'h1);
    drive(1, 0, 1, 0, 0, 16'hFFFF); step();
    check("wide_is_max", 32'(obs_mx[2]), 32'h1);
    drive(1, 0, 1, 0, 0, 16'h0000); step();
    check("wide_is_zero", 32'(obs_z[2]), 32'h1);

    // Randomized traffic with values biased toward the boundaries.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0:       d_pick = 16'h0000;
        1:       d_pick = 16'hFFFF;
        2:       d_pick = 16'hFFFE;
        3:       d_pick = 16'h0001;
        default: d_pick = 16'($urandom);
      endcase
      drive($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 7) != 0,
            1'($urandom), $urandom_range(0, 7) == 0, d_pick);
      step();
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
